// File: rtl/stream_rr_arbiter.sv
// Packet-granular round-robin arbiter for N valid/ready streams onto one output.
// A single-entry skid register keeps every in_ready driven straight from a flop.
module stream_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*DW-1:0] in_data,
    input  logic [N-1:0]    in_valid,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_valid,
    output logic            out_last,
    output logic [IW-1:0]   out_id,
    input  logic            out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        SKID = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    in_ready_q, in_ready_d;
    logic [DW-1:0]   skid_data_q, skid_data_d;
    logic            skid_last_q, skid_last_d;

    logic [DW-1:0]   in_data_a [N];
    logic            pick_found;
    logic [IW-1:0]   pick_idx;
    int unsigned     cand;
    logic            accept;

    // Successor of a requester index, wrapping N-1 -> 0 for any N.
    function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
        if (v == IW'(N - 1)) begin
            return '0;
        end
        return v + IW'(1);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    always_comb begin : unpack_data
        for (int i = 0; i < int'(N); i++) begin
            in_data_a[i] = in_data[i*DW +: DW];
        end
    end

    // First valid requester searching ptr, ptr+1, ..., wrapping back to ptr-1.
    always_comb begin : rr_pick
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!pick_found && in_valid[IW'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    always_comb begin : next_state
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        in_ready_d  = in_ready_q;
        skid_data_d = skid_data_q;
        skid_last_d = skid_last_q;
        accept      = in_valid[grant_q] & in_ready_q[grant_q];

        case (state_q)
            IDLE: begin
                in_ready_d = '0;
                if (pick_found) begin
                    grant_d    = pick_idx;
                    in_ready_d = onehot(pick_idx);
                    state_d    = PASS;
                end
            end
            PASS: begin
                if (accept) begin
                    if (out_ready) begin
                        if (in_last[grant_q]) begin
                            in_ready_d = '0;
                            ptr_d      = inc_wrap(grant_q);
                            state_d    = IDLE;
                        end
                    end else begin
                        // Downstream stalled on an accepted beat: park it.
                        skid_data_d = in_data_a[grant_q];
                        skid_last_d = in_last[grant_q];
                        in_ready_d  = '0;
                        state_d     = SKID;
                    end
                end
            end
            SKID: begin
                if (out_ready) begin
                    if (skid_last_q) begin
                        ptr_d   = inc_wrap(grant_q);
                        state_d = IDLE;
                    end else begin
                        in_ready_d = onehot(grant_q);
                        state_d    = PASS;
                    end
                end
            end
            default: begin
                in_ready_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_comb begin : out_mux
        out_id    = grant_q;
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            PASS: begin
                out_data  = in_data_a[grant_q];
                out_valid = in_valid[grant_q];
                out_last  = in_last[grant_q];
            end
            SKID: begin
                out_data  = skid_data_q;
                out_valid = 1'b1;
                out_last  = skid_last_q;
            end
            default: begin
                out_data  = '0;
                out_valid = 1'b0;
                out_last  = 1'b0;
            end
        endcase
    end

    assign in_ready = in_ready_q;

    always_ff @(posedge clk) begin : ctrl_regs
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            in_ready_q  <= '0;
            skid_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            in_ready_q  <= in_ready_d;
            skid_last_q <= skid_last_d;
        end
    end

    // Payload register is not reset; it is only read while in SKID.
    always_ff @(posedge clk) begin : skid_reg
        skid_data_q <= skid_data_d;
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(in_ready_q));

    a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
        32'(ptr_q) < N);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: per-requester beat queues drive the inputs,
// a scoreboard of hand-ordered expected beats is checked by an output monitor.
module tb_stream_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_last;
    logic [IW-1:0]   out_id;
    logic            out_ready;

    beat_t req_q [N][$];
    exp_t  exp_q [$];
    logic [N-1:0] fire;
    bit    prev_last_fire;
    int    n_tests;
    int    n_fail;

    stream_rr_arbiter #(.N(N), .DW(DW), .IW(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_beat(input int id, input logic [DW-1:0] d, input logic l, input bit expect_out);
        beat_t b;
        exp_t  e;
        b.data = d;
        b.last = l;
        req_q[id].push_back(b);
        if (expect_out) begin
            e.id   = IW'(id);
            e.data = d;
            e.last = l;
            exp_q.push_back(e);
        end
    endtask

    function automatic bit reqs_pending();
        for (int i = 0; i < int'(N); i++) begin
            if (req_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    // All main-thread waits land 2 time units after a rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_data(input string name, input logic [DW-1:0] v);
        int cyc;
        cyc = 0;
        while (!(out_valid === 1'b1 && out_data === v) && cyc < 100) begin
            step();
            cyc++;
        end
        if (cyc >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: timeout waiting for out_data %0h, last seen %0h", name, v, out_data);
        end
    endtask

    task automatic wait_drain(input string name);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || reqs_pending()) && cyc < 300) begin
            step();
            cyc++;
        end
        check({name, " drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Requester model: pop the beat that fired at the last edge, present the next head.
    initial begin
        in_data  = '0;
        in_valid = '0;
        in_last  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(N); i++) begin
                if (fire[i] && req_q[i].size() != 0) void'(req_q[i].pop_front());
                if (req_q[i].size() != 0) begin
                    in_valid[i]          = 1'b1;
                    in_data[i*DW +: DW]  = req_q[i][0].data;
                    in_last[i]           = req_q[i][0].last;
                end else begin
                    in_valid[i]          = 1'b0;
                    in_data[i*DW +: DW]  = '0;
                    in_last[i]           = 1'b0;
                end
            end
        end
    end

    // Output monitor: scoreboard compare on every handshake, plus idle gap after each last.
    initial begin
        fire           = '0;
        prev_last_fire = 1'b0;
        forever begin
            exp_t e;
            @(negedge clk);
            fire = (rst_n === 1'b1) ? (in_valid & in_ready) : '0;
            if (rst_n !== 1'b1) begin
                prev_last_fire = 1'b0;
            end else begin
                if (prev_last_fire) check("idle gap after last", 32'(out_valid), 32'd0);
                prev_last_fire = 1'b0;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected beat: got id %0d data %0h, expected none", out_id, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat id", 32'(out_id), 32'(e.id));
                        check("beat data", 32'(out_data), 32'(e.data));
                        check("beat last", 32'(out_last), 32'(e.last));
                    end
                    prev_last_fire = (out_last === 1'b1);
                end
            end
        end
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        out_ready = 1'b1;

        // Reset held with every requester offering a 1-beat packet.
        for (int i = 0; i < int'(N); i++) push_beat(i, 16'h0010 + 16'(i), 1'b1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("reset in_ready", 32'(in_ready), 32'h0);
            check("reset out_valid", 32'(out_valid), 32'h0);
        end
        rst_n = 1'b1;
        step();
        check("grant after reset", 32'(in_ready), 32'h1);
        wait_drain("reset order");

        // Single 4-beat packet from requester 0, back to back.
        for (int i = 0; i < 4; i++) push_beat(0, 16'h00A0 + 16'(i), 1'(i == 3), 1'b1);
        wait_data("single first", 16'h00A0);
        check("single in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("single data", 32'(out_data), 32'h00A0 + 32'(i));
            check("single id", 32'(out_id), 32'h0);
            check("single last", 32'(out_last), 32'(i == 3));
            step();
        end
        check("single ready drop", 32'(in_ready), 32'h0);
        check("single idle", 32'(out_valid), 32'h0);
        wait_drain("single");

        // Fairness from ptr=0: expected grant order 0,1,2,3,0,1.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        push_beat(0, 16'h0030, 1'b1, 1'b1);
        push_beat(1, 16'h0031, 1'b1, 1'b1);
        push_beat(2, 16'h0032, 1'b1, 1'b1);
        push_beat(3, 16'h0033, 1'b1, 1'b1);
        push_beat(0, 16'h0034, 1'b1, 1'b1);
        push_beat(1, 16'h0035, 1'b1, 1'b1);
        wait_drain("fairness");

        // Skid: stall 3 cycles while 0xB1 is offered by requester 2.
        for (int i = 0; i < 4; i++) push_beat(2, 16'h00B0 + 16'(i), 1'(i == 3), 1'b1);
        wait_data("skid B1", 16'h00B1);
        out_ready = 1'b0;
        step();
        check("skid valid", 32'(out_valid), 32'h1);
        check("skid data", 32'(out_data), 32'h00B1);
        check("skid in_ready", 32'(in_ready), 32'h0);
        step();
        check("skid hold data", 32'(out_data), 32'h00B1);
        step();
        out_ready = 1'b1;
        wait_drain("skid");

        // Stalled last beat of requester 1, then ptr must point at 2.
        push_beat(1, 16'h00C0, 1'b0, 1'b1);
        push_beat(1, 16'h00C1, 1'b1, 1'b1);
        wait_data("stall last C1", 16'h00C1);
        out_ready = 1'b0;
        step();
        check("stall last valid", 32'(out_valid), 32'h1);
        check("stall last flag", 32'(out_last), 32'h1);
        check("stall last in_ready", 32'(in_ready), 32'h0);
        step();
        out_ready = 1'b1;
        step();
        check("stall release idle", 32'(out_valid), 32'h0);
        check("stall release in_ready", 32'(in_ready), 32'h0);
        step();
        check("no extra pulse", 32'(in_ready), 32'h0);
        wait_drain("stall last");
        push_beat(2, 16'h00F2, 1'b1, 1'b1);
        push_beat(0, 16'h00F0, 1'b1, 1'b1);
        push_beat(1, 16'h00F1, 1'b1, 1'b1);
        wait_drain("ptr after stall");

        // Reset mid-packet after two of four beats from requester 3.
        for (int i = 0; i < 4; i++) push_beat(3, 16'h00D0 + 16'(i), 1'(i == 3), i < 2);
        wait_data("midreset D2", 16'h00D2);
        rst_n = 1'b0;
        step();
        check("midreset in_ready", 32'(in_ready), 32'h0);
        check("midreset out_valid", 32'(out_valid), 32'h0);
        req_q[3].delete();
        step();
        rst_n = 1'b1;
        push_beat(1, 16'h00E0, 1'b0, 1'b1);
        push_beat(1, 16'h00E1, 1'b1, 1'b1);
        wait_data("post reset E0", 16'h00E0);
        check("post reset id", 32'(out_id), 32'h1);
        wait_drain("post reset");

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one downstream valid/ready stream between N upstream requesters at packet granularity. It has a single-entry skid register so that every `in_ready` output is driven straight from a flop, with no combinational path from `out_ready`. It sits in front of a shared pipeline stage, typically a skid buffer feeding a common consumer. A grant is held from the first beat of a packet until its `last` beat is accepted.

## Interface
- `N`, default 4: number of requesters, N ≥ 2.
- `DW`, default 16: data width.
- `IW`, default `$clog2(N)`: width of the source-id output.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_data`  in  N*DW  requester i uses bits [i*DW +: DW].
- `in_valid`  in  N  per-requester valid.
- `in_last`  in  N  per-requester end-of-packet flag, qualified by `in_valid`.
- `in_ready`  out  N  per-requester ready; registered, at most one bit set (one-hot or zero).
- `out_data`  out  DW  granted data.
- `out_valid`  out  1  downstream valid.
- `out_last`  out  1  downstream end-of-packet.
- `out_id`  out  IW  index of the current grant; meaningful only while `out_valid` = 1.
- `out_ready`  in  1  downstream ready.

## Operation
- Transfer rule: a beat moves when valid & ready are both 1 on the same edge. Requesters hold data, last and valid stable until accepted.
- State registers:
  - `state` ∈ {IDLE, PASS, SKID}
  - `grant` (IW bits)
  - `ptr` (IW bits, round-robin priority pointer)
  - `skid_data`, `skid_last`
  - `in_ready` (N flops)
- IDLE:
  - `out_valid` = 0, `in_ready` = 0.
  - If any `in_valid` is 1, select the first set index searching `ptr`, `ptr`+1, …, N-1, 0, …, `ptr`-1.
  - Load that index into `grant`, set `in_ready[grant]` = 1, go to PASS.
  - Otherwise stay in IDLE.
- PASS (bypass path):
  - `out_data`/`out_last`/`out_valid` = `in_data`/`in_last`/`in_valid` of the granted requester; `out_id` = `grant`.
  - `in_ready[grant]` = 1.
  - Input beat accepted and `out_ready` = 1, `in_last` = 0: stay in PASS.
  - Input beat accepted and `out_ready` = 1, `in_last` = 1: clear `in_ready`, set `ptr` = (`grant`+1) mod N, go to IDLE.
  - Input beat accepted and `out_ready` = 0: capture data and last into the skid register, clear `in_ready`, go to SKID.
  - No input beat: stay in PASS.
- SKID:
  - Output is driven from the skid register; `out_valid` = 1, `out_id` = `grant`, `in_ready` = 0.
  - `out_ready` = 1 and `skid_last` = 1: set `ptr` = `grant`+1 mod N, go to IDLE.
  - `out_ready` = 1 and `skid_last` = 0: set `in_ready[grant]` = 1, go to PASS.
  - `out_ready` = 0: hold.
- The skid register is written only on the PASS→SKID transition.
- Requesters that are not granted always see `in_ready` = 0. Their `in_valid` has no effect until the next IDLE evaluation.
- `ptr` wraps from N-1 to 0. With N not a power of two, `ptr` never holds a value ≥ N.

## Timing
- Reset (`rst_n` = 0 at an edge) forces, on that edge:
  - `state` = IDLE, `ptr` = 0, `grant` = 0, `in_ready` = 0, `skid_last` = 0.
  - Hence `out_valid` = 0 and `out_last` = 0.
  - `skid_data` is not reset.
- Reset mid-packet is allowed: the partial packet is abandoned and the arbiter returns to IDLE the next cycle.
- Grant latency: `in_valid` seen in IDLE at edge t gives `in_ready` = 1 from t+1.
- Forward latency in PASS is 0 cycles: output equals input in the same cycle.
- Packet turnaround: `last` accepted at edge t in PASS gives IDLE during t..t+1, and the next grant's `in_ready` is 1 from t+2. That is one idle output cycle between packets.
- Backpressure: at most one beat lands in the skid register, because `in_ready` drops on the edge after capture.
- Stream integrity: no beat is dropped, duplicated or reordered.
- Sustained `out_ready` = 1 gives 1 beat per cycle within a packet.
- A single-beat packet (`last` on the first beat) is legal and follows the same rules.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles with all `in_valid` = 1 → `in_ready` = 0000, `out_valid` = 0 throughout. After release, `in_ready` = 0001 one cycle later.
- Single packet: requester 0 sends 4 beats 0xA0..0xA3, `last` on 0xA3, `out_ready` = 1 → `out_data` shows 0xA0..0xA3 on consecutive cycles with `out_id` = 0 and `out_last` only on 0xA3. `in_ready[0]` falls the cycle after 0xA3.
- Fairness: all 4 requesters continuously offer 1-beat packets → grant order 0,1,2,3,0,1. Each grant is separated by one IDLE cycle.
- Skid: requester 2 sends 0xB0..0xB3 and `out_ready` = 0 for 3 cycles during 0xB1 → 0xB1 is held in the skid register with `out_valid` = 1, and `in_ready[2]` = 0 the next cycle. After release the output sequence is exactly 0xB0,0xB1,0xB2,0xB3.
- Stalled last beat: `out_ready` = 0 when the `last` beat is accepted → SKID state with `out_last` = 1. On `out_ready` = 1, go to IDLE with `ptr` = grant+1, and no extra `in_ready` pulse to the same requester.
- Reset mid-packet: assert `rst_n` = 0 after beat 2 of 4 from requester 3 → on the next edge `in_ready` = 0, `out_valid` = 0, `ptr` = 0. A new request from requester 1 is granted normally afterwards.
